// File: rtl/fios_modexp_sched_pkg.sv
// Shared encodings for the FIOS modular-exponentiation scheduler:
// operand selects, operation codes, FSM states and result destinations.
package fios_sched_pkg;

    typedef enum logic [2:0] {
        X_IN   = 3'd0,
        ACC    = 3'd1,
        XM     = 3'd2,
        R2     = 3'd3,
        ONE    = 3'd4,
        R_MODN = 3'd5
    } opsel_e;

    typedef enum logic [1:0] {
        CONV = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        EXIT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic DST_ACC = 1'b0;
    localparam logic DST_XM  = 1'b1;

    // Until ACC has been written it holds nothing useful, so Montgomery 1 stands in.
    function automatic opsel_e acc_operand(input logic acc_valid);
        return acc_valid ? ACC : R_MODN;
    endfunction

endpackage

// File: rtl/fios_modexp_sched.sv
// Left-to-right square-and-multiply sequencer driving one FIOS Montgomery
// multiplier through a start/done handshake, including domain entry and exit.
module fios_modexp_sched
    import fios_sched_pkg::*;
#(
    parameter int s     = 16,
    parameter int EXP_W = 64,
    localparam int LEN_W = $clog2(EXP_W + 1),
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [LEN_W-1:0] exp_len_i,
    output logic             mm_start_o,
    input  logic             mm_done_i,
    output logic [2:0]       op_a_sel_o,
    output logic [2:0]       op_b_sel_o,
    output logic             res_we_o,
    output logic             res_dst_o,
    output logic             busy_o,
    output logic             done_o
);

    if (s < 1 || EXP_W < 1) begin : g_param_check
        $error("fios_modexp_sched: s and EXP_W must be positive");
    end

    state_e             state_reg,     state_next;
    op_e                op_reg,        op_next;
    logic [EXP_W-1:0]   exp_reg,       exp_next;
    logic [IDX_W-1:0]   bit_idx_reg,   bit_idx_next;
    logic               acc_valid_reg, acc_valid_next;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   len_m1;
    opsel_e             acc_src;
    opsel_e             sel_a;
    opsel_e             sel_b;
    logic               sel_dst;
    logic               drive_sel;

    assign len_clamped = (exp_len_i > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : exp_len_i;
    assign len_m1      = len_clamped - LEN_W'(1);
    assign acc_src     = acc_operand(acc_valid_reg);

    always_comb begin
        sel_a   = acc_src;
        sel_b   = ONE;
        sel_dst = DST_ACC;
        case (op_reg)
            CONV: begin
                sel_a   = X_IN;
                sel_b   = R2;
                sel_dst = DST_XM;
            end
            SQ: begin
                sel_a = acc_src;
                sel_b = acc_src;
            end
            MUL: begin
                sel_a = acc_src;
                sel_b = XM;
            end
            EXIT: begin
                sel_a = acc_src;
                sel_b = ONE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            op_reg        <= CONV;
            exp_reg       <= '0;
            bit_idx_reg   <= '0;
            acc_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            exp_reg       <= exp_next;
            bit_idx_reg   <= bit_idx_next;
            acc_valid_reg <= acc_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        exp_next       = exp_reg;
        bit_idx_next   = bit_idx_reg;
        acc_valid_next = acc_valid_reg;
        mm_start_o     = 1'b0;
        res_we_o       = 1'b0;
        done_o         = 1'b0;
        drive_sel      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    exp_next   = exp_i;
                    state_next = ISSUE;
                    if (len_clamped != '0) begin
                        op_next      = CONV;
                        bit_idx_next = len_m1[IDX_W-1:0];
                    end else begin
                        op_next = EXIT;
                    end
                end
            end
            ISSUE: begin
                mm_start_o = 1'b1;
                drive_sel  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                drive_sel = 1'b1;
                if (mm_done_i) begin
                    state_next = WB;
                end
            end
            WB: begin
                drive_sel  = 1'b1;
                res_we_o   = 1'b1;
                state_next = ISSUE;
                if (sel_dst == DST_ACC) begin
                    acc_valid_next = 1'b1;
                end
                // Step down the exponent after each bit's square (and multiply, if set).
                case (op_reg)
                    CONV: op_next = SQ;
                    SQ: begin
                        if (exp_reg[bit_idx_reg]) begin
                            op_next = MUL;
                        end else if (bit_idx_reg == '0) begin
                            op_next = EXIT;
                        end else begin
                            op_next      = SQ;
                            bit_idx_next = bit_idx_reg - IDX_W'(1);
                        end
                    end
                    MUL: begin
                        if (bit_idx_reg == '0) begin
                            op_next = EXIT;
                        end else begin
                            op_next      = SQ;
                            bit_idx_next = bit_idx_reg - IDX_W'(1);
                        end
                    end
                    EXIT: state_next = FIN;
                endcase
            end
            FIN: begin
                done_o         = 1'b1;
                acc_valid_next = 1'b0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign op_a_sel_o = drive_sel ? sel_a : 3'd0;
    assign op_b_sel_o = drive_sel ? sel_b : 3'd0;
    assign res_dst_o  = drive_sel ? sel_dst : 1'b0;
    assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_fios_modexp_sched.sv
// Directed bench for fios_modexp_sched with a fixed-latency multiplier responder.
module tb_fios_modexp_sched;

    localparam int EXP_W = 64;
    localparam int LEN_W = $clog2(EXP_W + 1);

    localparam logic [2:0] S_X   = 3'd0;
    localparam logic [2:0] S_ACC = 3'd1;
    localparam logic [2:0] S_XM  = 3'd2;
    localparam logic [2:0] S_R2  = 3'd3;
    localparam logic [2:0] S_ONE = 3'd4;
    localparam logic [2:0] S_RM  = 3'd5;
    localparam logic D_ACC = 1'b0;
    localparam logic D_XM  = 1'b1;

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic [EXP_W-1:0] exp_i;
    logic [LEN_W-1:0] exp_len_i;
    logic             mm_start_o;
    logic             mm_done_i;
    logic [2:0]       op_a_sel_o;
    logic [2:0]       op_b_sel_o;
    logic             res_we_o;
    logic             res_dst_o;
    logic             busy_o;
    logic             done_o;

    logic model_done;
    logic spurious_done;
    int   lat;

    logic [6:0] issue_q[$];
    logic       wb_q[$];
    logic [6:0] exp_q[$];
    int         done_cnt;
    int         proto_err;
    int         sel_err;

    int passed;
    int total;
    int fails;

    assign mm_done_i = model_done | spurious_done;

    fios_modexp_sched #(.s(16), .EXP_W(EXP_W)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .exp_i      (exp_i),
        .exp_len_i  (exp_len_i),
        .mm_start_o (mm_start_o),
        .mm_done_i  (mm_done_i),
        .op_a_sel_o (op_a_sel_o),
        .op_b_sel_o (op_b_sel_o),
        .res_we_o   (res_we_o),
        .res_dst_o  (res_dst_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial forever #5 clock_i = ~clock_i;

    // Multiplier stand-in: done pulse lat cycles after each observed start.
    initial begin
        model_done = 1'b0;
        forever begin
            @(negedge clock_i);
            if (mm_start_o) begin
                repeat (lat) @(negedge clock_i);
                model_done = 1'b1;
                @(negedge clock_i);
                model_done = 1'b0;
            end
        end
    end

    // Transaction monitor: one line per issued multiplication.
    initial begin
        bit outstanding;
        outstanding = 1'b0;
        done_cnt = 0;
        proto_err = 0;
        sel_err = 0;
        forever begin
            @(negedge clock_i);
            if (reset_i) begin
                outstanding = 1'b0;
            end else begin
                if (op_a_sel_o > 3'd5 || op_b_sel_o > 3'd5) sel_err++;
                if (mm_start_o) begin
                    if (outstanding) proto_err++;
                    outstanding = 1'b1;
                    issue_q.push_back({op_a_sel_o, op_b_sel_o, res_dst_o});
                    $display("issue #%0d: a=%0d b=%0d dst=%0d", issue_q.size(),
                             op_a_sel_o, op_b_sel_o, res_dst_o);
                end
                if (res_we_o) begin
                    wb_q.push_back(res_dst_o);
                    outstanding = 1'b0;
                end
                if (done_o) done_cnt++;
            end
        end
    end

    function automatic logic [6:0] ent(input logic [2:0] a, input logic [2:0] b, input logic d);
        return {a, b, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_seq_1011();
        exp_q.delete();
        exp_q.push_back(ent(S_X,   S_R2,  D_XM));
        exp_q.push_back(ent(S_RM,  S_RM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_XM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_ACC, D_ACC));
        exp_q.push_back(ent(S_ACC, S_ACC, D_ACC));
        exp_q.push_back(ent(S_ACC, S_XM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_ACC, D_ACC));
        exp_q.push_back(ent(S_ACC, S_XM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_ONE, D_ACC));
    endtask

    task automatic check_seq(input string tag, input int ibase, input int wbase, input int dbase);
        chk({tag, " issue count"}, issue_q.size() - ibase, exp_q.size());
        chk({tag, " wb count"}, wb_q.size() - wbase, exp_q.size());
        chk({tag, " done count"}, done_cnt - dbase, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ibase + i < issue_q.size())
                chk($sformatf("%s op[%0d]", tag, i), issue_q[ibase + i], exp_q[i]);
            if (wbase + i < wb_q.size())
                chk($sformatf("%s wb dst[%0d]", tag, i), wb_q[wbase + i], exp_q[i][0]);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 5000) begin
            @(negedge clock_i);
            start_i = 1'b0;
            n++;
        end
        chk({tag, " done seen"}, done_o, 1'b1);
        @(negedge clock_i);
        chk({tag, " busy dropped"}, busy_o, 1'b0);
        repeat (2) @(negedge clock_i);
    endtask

    task automatic run_exp(input logic [EXP_W-1:0] e, input int len, input int l, input string tag);
        int ib, wbb, db;
        ib = issue_q.size();
        wbb = wb_q.size();
        db = done_cnt;
        lat = l;
        @(negedge clock_i);
        start_i = 1'b1;
        exp_i = e;
        exp_len_i = LEN_W'(len);
        @(negedge clock_i);
        start_i = 1'b0;
        chk({tag, " start->mm_start latency"}, {mm_start_o, busy_o}, 2'b11);
        exp_i = ~e;
        exp_len_i = '0;
        wait_done(tag);
        check_seq(tag, ib, wbb, db);
    endtask

    initial begin
        int ib, wbb, db, spur_n, n;
        passed = 0;
        total = 0;
        fails = 0;
        lat = 10;
        reset_i = 1'b1;
        start_i = 1'b0;
        exp_i = '0;
        exp_len_i = '0;
        spurious_done = 1'b0;

        repeat (3) @(negedge clock_i);
        chk("reset outputs", {mm_start_o, op_a_sel_o, op_b_sel_o, res_we_o, res_dst_o, busy_o, done_o}, 0);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("idle outputs", {mm_start_o, op_a_sel_o, op_b_sel_o, res_we_o, res_dst_o, busy_o, done_o}, 0);

        // E=1011, 4 bits
        load_seq_1011();
        run_exp(64'b1011, 4, 10, "e1011");

        // Empty exponent: only the exit multiplication
        exp_q.delete();
        exp_q.push_back(ent(S_RM, S_ONE, D_ACC));
        run_exp(64'h0, 0, 3, "len0");

        // E=1: first square uses Montgomery 1 for both operands
        exp_q.delete();
        exp_q.push_back(ent(S_X,   S_R2,  D_XM));
        exp_q.push_back(ent(S_RM,  S_RM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_XM,  D_ACC));
        exp_q.push_back(ent(S_ACC, S_ONE, D_ACC));
        run_exp(64'h1, 1, 2, "e1");

        // Oversized length clamps to EXP_W: 1 + EXP_W squares + EXP_W multiplies + 1
        exp_q.delete();
        exp_q.push_back(ent(S_X, S_R2, D_XM));
        exp_q.push_back(ent(S_RM, S_RM, D_ACC));
        exp_q.push_back(ent(S_ACC, S_XM, D_ACC));
        for (int i = 1; i < EXP_W; i++) begin
            exp_q.push_back(ent(S_ACC, S_ACC, D_ACC));
            exp_q.push_back(ent(S_ACC, S_XM, D_ACC));
        end
        exp_q.push_back(ent(S_ACC, S_ONE, D_ACC));
        chk("clamp model size", exp_q.size(), 1 + EXP_W + EXP_W + 1);
        run_exp({EXP_W{1'b1}}, EXP_W + 5, 1, "clamp");

        // Spurious done in IDLE, then starts while busy and spurious done in ISSUE
        @(negedge clock_i);
        spurious_done = 1'b1;
        @(negedge clock_i);
        spurious_done = 1'b0;
        chk("spurious done in idle", {busy_o, mm_start_o, res_we_o}, 3'b000);
        load_seq_1011();
        ib = issue_q.size();
        wbb = wb_q.size();
        db = done_cnt;
        lat = 4;
        start_i = 1'b1;
        exp_i = 64'b1011;
        exp_len_i = LEN_W'(4);
        @(negedge clock_i);
        start_i = 1'b0;
        spur_n = 0;
        n = 0;
        while (!done_o && n < 2000) begin
            spurious_done = (mm_start_o && spur_n < 3);
            if (mm_start_o && spur_n < 3) spur_n++;
            start_i = (n == 3 || n == 17);
            exp_i = '0;
            exp_len_i = LEN_W'(2);
            @(negedge clock_i);
            n++;
        end
        spurious_done = 1'b0;
        start_i = 1'b0;
        chk("interfere spurious pulses", spur_n, 3);
        wait_done("interfere");
        check_seq("interfere", ib, wbb, db);

        // Reset while waiting on the multiplier
        load_seq_1011();
        ib = issue_q.size();
        lat = 10;
        @(negedge clock_i);
        start_i = 1'b1;
        exp_i = 64'b1011;
        exp_len_i = LEN_W'(4);
        @(negedge clock_i);
        start_i = 1'b0;
        n = 0;
        while (issue_q.size() < ib + 2 && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        chk("reset test reached 2nd op", issue_q.size() - ib, 2);
        repeat (3) @(negedge clock_i);
        chk("in wait before reset", {busy_o, mm_start_o, res_we_o}, 3'b100);
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        chk("outputs after mid reset", {mm_start_o, op_a_sel_o, op_b_sel_o, res_we_o, res_dst_o, busy_o, done_o}, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
        ib = issue_q.size();
        wbb = wb_q.size();
        db = done_cnt;
        repeat (20) @(negedge clock_i);
        chk("no strobes after reset", {issue_q.size() - ib, wb_q.size() - wbb, done_cnt - db}, 0);
        chk("idle after reset", busy_o, 1'b0);
        run_exp(64'b1011, 4, 10, "after reset");

        chk("handshake overlap", proto_err, 0);
        chk("select range", sel_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fios_modexp_sched.md
Name: fios_modexp_sched

Overview:
Sequencer that drives one FIOS Montgomery multiplier (start/done handshake) to compute a modular exponentiation X^E mod N by left-to-right square-and-multiply.
- Selects the A/B operand sources and the result destination for each multiplication.
- Handles Montgomery entry (multiply by R^2 mod N) and exit (multiply by 1).
- Sits above the multiplier's PE-chain control FSM and below the host/register interface.

Parameters:
- s, 16, operand width in words; passed through only, sizes nothing here.
- EXP_W, 64, maximum exponent width in bits.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  begin exponentiation; sampled only in IDLE
- exp_i  in  EXP_W  exponent E; latched on accepted start_i
- exp_len_i  in  $clog2(EXP_W+1)  number of significant exponent bits; latched with exp_i
- mm_start_o  out  1  one-cycle start pulse to the multiplier
- mm_done_i  in  1  multiplier completion pulse
- op_a_sel_o  out  3  A operand source (encoding in package)
- op_b_sel_o  out  3  B operand source
- res_we_o  out  1  one-cycle write strobe for the multiplier result
- res_dst_o  out  1  destination: 0 = ACC, 1 = XM
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse; final result is in ACC

Behaviour:
- Reset: state IDLE. All outputs 0 (selects 0). Exponent register, bit index, op register and acc_valid cleared. Reset mid-operation aborts immediately; no further strobes are issued.
- Operand encoding:
  - 0 X_IN, 1 ACC, 2 XM, 3 R2 (R^2 mod N), 4 ONE, 5 R_MODN.
  - 6 and 7 are never driven.
  - While acc_valid=0, every ACC operand is driven as R_MODN (Montgomery 1).
- State machine: IDLE, ISSUE, WAIT, WB, FIN. The op register holds CONV, SQ, MUL or EXIT.
- IDLE:
  - On start_i, latch exp_i and min(exp_len_i, EXP_W) as len.
  - If len>0: op=CONV, bit_idx=len-1. If len=0: op=EXIT.
  - Go to ISSUE and set busy_o.
- ISSUE (1 cycle): mm_start_o=1, selects driven per op, then go to WAIT.
  - CONV: A=X_IN, B=R2, dst=XM.
  - SQ: A=ACC, B=ACC, dst=ACC.
  - MUL: A=ACC, B=XM, dst=ACC.
  - EXIT: A=ACC, B=ONE, dst=ACC.
- WAIT: selects held stable. On mm_done_i go to WB. mm_done_i in any other state is ignored.
- WB (1 cycle):
  - Assert res_we_o with res_dst_o. Selects stay held this cycle.
  - If dst=ACC, set acc_valid.
  - Next op:
    - CONV -> SQ.
    - SQ -> MUL if exp[bit_idx]=1; else (bit_idx=0 ? EXIT : SQ with bit_idx-1).
    - MUL -> (bit_idx=0 ? EXIT : SQ with bit_idx-1).
    - EXIT -> FIN.
  - Any next op other than FIN goes to ISSUE.
- FIN (1 cycle): done_o=1, busy_o drops the following cycle, return to IDLE, clear acc_valid.
- Latency:
  - start_i at cycle t gives mm_start_o at t+1.
  - Each multiplication costs 3 scheduler cycles plus the multiplier latency.
  - Total multiplications: (len>0 ? 1 : 0) + len + popcount(exp[len-1:0]) + 1.
- start_i while busy is ignored; exp_i and exp_len_i changes while busy have no effect.
- mm_start_o never reasserts before the matching mm_done_i has been seen.

Decomposition:
- Package fios_sched_pkg holds:
  - operand-select enum (X_IN..R_MODN, 3 bits)
  - op enum (CONV, SQ, MUL, EXIT)
  - state enum (IDLE, ISSUE, WAIT, WB, FIN)
  - destination constants (DST_ACC=0, DST_XM=1)
- No sub-module. A single FSM with a bit-index down-counter is natural.

Test Plan:
- exp_i=4'b1011, exp_len_i=4, mm_done_i 10 cycles after each start -> op sequence CONV,SQ,MUL,SQ,SQ,MUL,SQ,MUL,EXIT. Exactly 9 mm_start_o and 9 res_we_o, one done_o.
- exp_len_i=0 -> single EXIT op with A=R_MODN, B=ONE, dst=ACC, then done_o. No CONV issued.
- exp_i=1, exp_len_i=1 -> CONV, SQ with both selects=R_MODN (acc_valid=0), MUL, EXIT. 4 multiplications.
- exp_len_i=EXP_W+5 with all-ones exp -> clamped. Multiplication count = 1+EXP_W+EXP_W+1.
- start_i pulsed while busy, and spurious mm_done_i in ISSUE/IDLE -> ignored. Sequence and counts unchanged.
- reset_i asserted in WAIT mid-sequence -> next cycle all outputs 0 and state IDLE. A fresh start_i then runs a full correct sequence.
